newton_rapson_axil_slave: RTL and testbench

//  AXI4-Lite slave register front-end for the NewtonRapson peripheral; responds to the AXI master VIP / PS.

---
 rtl/newton_rapson_pkg.sv | 50 +++++
 rtl/newton_rapson_axil_slave.sv | 196 +++++++++++++++++++
 tb/tb_newton_rapson_axil_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/newton_rapson_pkg.sv
// Shared definitions for the NewtonRapson AXI4-Lite register front-end:
// bus widths, register indices, CTRL/STATUS bit positions, response code
// and the WSTRB byte-merge helper.
package newton_rapson_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Register index = byte address [3:2]
  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_OPERAND = 2'd1,
    REG_RESULT  = 2'd2,
    REG_STATUS  = 2'd3
  } reg_idx_e;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;

  // Captured write-data beat
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wbeat_t;

  function automatic reg_idx_e addr_to_idx(input logic [ADDR_W-1:0] addr);
    return reg_idx_e'(addr[3:2]);
  endfunction

  // Replace only the bytes whose strobe is set
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/newton_rapson_axil_slave.sv
// AXI4-Lite slave register front-end for the NewtonRapson core.
// Captures AW/W independently, applies the register write once both are held,
// returns registered read data, launches the core with a one-cycle start pulse
// and captures its result on done.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address / data / response channels
//   S_AXI_AR* / S_AXI_R*            : read address / data channels
//   core_start, core_operand        : launch pulse and operand to the NR core
//   core_done, core_result          : completion pulse and result from the core
//   irq                             : level interrupt, DONE & IRQ_EN
module newton_rapson_axil_slave
  import newton_rapson_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_operand,
  input  logic                            core_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_result,
  output logic                            irq
);

  // Protection bits and byte-offset address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  // Registered state
  logic              aw_held, w_held;
  reg_idx_e          aw_idx;
  wbeat_t            w_beat;
  logic [DATA_W-1:0] operand, result;
  logic              irq_en, busy, done, err;

  // Next-state values
  logic              aw_held_n, w_held_n, awready_n, wready_n, bvalid_n;
  reg_idx_e          aw_idx_n;
  wbeat_t            w_beat_n;
  logic              arready_n, rvalid_n;
  logic [DATA_W-1:0] rdata_n, rd_word;
  logic [DATA_W-1:0] operand_n, result_n;
  logic              irq_en_n, busy_n, done_n, err_n, start_n, irq_n;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, do_write, start_req;

  // Read mux, sampled on the AR handshake
  always_comb begin
    rd_word = '0;
    case (addr_to_idx(S_AXI_ARADDR))
      REG_CTRL:    rd_word[CTRL_IRQ_EN] = irq_en;
      REG_OPERAND: rd_word = operand;
      REG_RESULT:  rd_word = result;
      REG_STATUS: begin
        rd_word[STAT_BUSY] = busy;
        rd_word[STAT_DONE] = done;
        rd_word[STAT_ERR]  = err;
      end
      default: rd_word = '0;
    endcase
  end

  // Channel handshakes and register next-state
  always_comb begin
    aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    b_hs  = S_AXI_BVALID & S_AXI_BREADY;
    ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    r_hs  = S_AXI_RVALID & S_AXI_RREADY;

    // Both halves held and no response outstanding: commit the write now
    do_write = aw_held & w_held & ~S_AXI_BVALID;

    aw_held_n = aw_held;
    aw_idx_n  = aw_idx;
    w_held_n  = w_held;
    w_beat_n  = w_beat;
    if (aw_hs) begin
      aw_held_n = 1'b1;
      aw_idx_n  = addr_to_idx(S_AXI_AWADDR);
    end
    if (w_hs) begin
      w_held_n = 1'b1;
      w_beat_n = '{data: S_AXI_WDATA, strb: S_AXI_WSTRB};
    end
    if (b_hs) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
    end
    bvalid_n  = do_write ? 1'b1 : (b_hs ? 1'b0 : S_AXI_BVALID);
    awready_n = ~aw_held_n & ~bvalid_n;
    wready_n  = ~w_held_n & ~bvalid_n;

    rvalid_n  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : S_AXI_RVALID);
    rdata_n   = ar_hs ? rd_word : S_AXI_RDATA;
    arready_n = ~rvalid_n;

    operand_n = operand;
    result_n  = result;
    irq_en_n  = irq_en;
    busy_n    = busy;
    done_n    = done;
    err_n     = err;

    start_req = do_write & (aw_idx == REG_CTRL) & w_beat.strb[0] & w_beat.data[CTRL_START];
    start_n   = start_req & ~busy;

    if (do_write && aw_idx == REG_CTRL && w_beat.strb[0]) irq_en_n = w_beat.data[CTRL_IRQ_EN];
    if (do_write && aw_idx == REG_OPERAND) operand_n = byte_merge(operand, w_beat.data, w_beat.strb);
    if (do_write && aw_idx == REG_STATUS && w_beat.strb[0]) begin
      if (w_beat.data[STAT_DONE]) done_n = 1'b0;
      if (w_beat.data[STAT_ERR])  err_n  = 1'b0;
    end
    if (start_req && busy) err_n = 1'b1;
    if (start_n) done_n = 1'b0;
    // Completion overrides a same-cycle DONE clear; a same-cycle start keeps BUSY
    if (core_done) begin
      result_n = core_result;
      busy_n   = 1'b0;
      done_n   = 1'b1;
    end
    if (start_n) busy_n = 1'b1;

    irq_n = done_n & irq_en_n;
  end

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held       <= 1'b0;
      aw_idx        <= REG_CTRL;
      w_held        <= 1'b0;
      w_beat        <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      operand       <= '0;
      result        <= '0;
      irq_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      core_start    <= 1'b0;
      irq           <= 1'b0;
    end else begin
      aw_held       <= aw_held_n;
      aw_idx        <= aw_idx_n;
      w_held        <= w_held_n;
      w_beat        <= w_beat_n;
      S_AXI_AWREADY <= awready_n;
      S_AXI_WREADY  <= wready_n;
      S_AXI_BVALID  <= bvalid_n;
      S_AXI_ARREADY <= arready_n;
      S_AXI_RVALID  <= rvalid_n;
      S_AXI_RDATA   <= rdata_n;
      operand       <= operand_n;
      result        <= result_n;
      irq_en        <= irq_en_n;
      busy          <= busy_n;
      done          <= done_n;
      err           <= err_n;
      core_start    <= start_n;
      irq           <= irq_n;
    end
  end

  assign core_operand = operand;

endmodule

// File: tb/tb_newton_rapson_axil_slave.sv
// Self-checking bench for newton_rapson_axil_slave: directed register vectors,
// out-of-order write channels, start/done/error flow with a behavioural core,
// back-pressure stability, randomized register traffic against a reference
// model, and asynchronous reset with transactions in flight.
module tb_newton_rapson_axil_slave;

  localparam int TMO = 200;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        core_start, irq;
  logic [31:0] core_operand;
  logic        core_done = 1'b0;
  logic [31:0] core_result = '0;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  newton_rapson_axil_slave dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_start(core_start), .core_operand(core_operand),
    .core_done(core_done), .core_result(core_result), .irq(irq)
  );

  // Behavioural NR core: finishes core_lat cycles after each start pulse
  int          core_lat = 20;
  logic [31:0] core_res_val = '0;
  int          cm_cnt = 0;
  int          cm_done_cnt = 0;
  logic [31:0] cm_result = '0;
  int          starts = 0;
  int          width_viol = 0;
  logic        prev_start = 1'b0;

  always @(negedge aclk) begin
    core_done = 1'b0;
    if (!aresetn) begin
      cm_cnt = 0;
      prev_start = 1'b0;
    end else begin
      if (core_start) begin
        starts++;
        if (prev_start) width_viol++;
        cm_cnt = core_lat;
      end else if (cm_cnt > 0) begin
        cm_cnt--;
        if (cm_cnt == 0) begin
          core_done   = 1'b1;
          core_result = core_res_val;
          cm_result   = core_res_val;
          cm_done_cnt++;
        end
      end
      prev_start = core_start;
    end
  end

  // Reference model of the register file
  logic [31:0] m_operand = '0, m_result = '0;
  logic        m_irq_en = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int          exp_starts = 0;
  int          seen_done = 0;

  function automatic void model_sync();
    if (cm_done_cnt != seen_done) begin
      seen_done = cm_done_cnt;
      m_result  = cm_result;
      m_busy    = 1'b0;
      m_done    = 1'b1;
    end
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    model_sync();
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    case (addr[3:2])
      2'd0: if (strb[0]) begin
        m_irq_en = data[1];
        if (data[0]) begin
          if (m_busy) m_err = 1'b1;
          else begin m_busy = 1'b1; m_done = 1'b0; exp_starts++; end
        end
      end
      2'd1: m_operand = (m_operand & ~mask) | (data & mask);
      2'd3: if (strb[0]) begin
        if (data[1]) m_done = 1'b0;
        if (data[2]) m_err  = 1'b0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    model_sync();
    case (addr[3:2])
      2'd0:    return {30'd0, m_irq_en, 1'b0};
      2'd1:    return m_operand;
      2'd2:    return m_result;
      default: return {29'd0, m_err, m_done, m_busy};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(awready), 32'd0);
    check({tag, "_wready"}, 32'(wready), 32'd0);
    check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    check({tag, "_arready"}, 32'(arready), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
    check({tag, "_core_operand"}, core_operand, 32'd0);
  endtask

  // AXI write with per-channel start delays and a BREADY stall
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0;
    int cyc = 0;
    @(negedge aclk);
    while (!(aw_done && w_done) && cyc < TMO) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      if (cyc > 0) check("b_before_both", 32'(bvalid), 32'd0);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge aclk);
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (cyc >= TMO) check("aw_w_timeout", 32'd1, 32'd0);
    cyc = 0;
    while (!bvalid && cyc < TMO) begin @(negedge aclk); cyc++; end
    if (cyc >= TMO) check("bvalid_timeout", 32'd1, 32'd0);
    check("bresp", 32'(bresp), 32'd0);
    for (int k = 0; k < b_dly; k++) begin
      @(negedge aclk);
      check("b_stall_bvalid", 32'(bvalid), 32'd1);
      check("b_stall_awready", 32'(awready), 32'd0);
      check("b_stall_wready", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
    model_write(addr, data, strb);
  endtask

  // AXI read with an RREADY stall
  task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
    int cyc = 0;
    @(negedge aclk);
    arvalid = 1'b1;
    araddr  = addr;
    while (!arready && cyc < TMO) begin @(negedge aclk); cyc++; end
    if (cyc >= TMO) check("arready_timeout", 32'd1, 32'd0);
    @(negedge aclk);
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < TMO) begin @(negedge aclk); cyc++; end
    if (cyc >= TMO) check("rvalid_timeout", 32'd1, 32'd0);
    data = rdata;
    check("rresp", 32'(rresp), 32'd0);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge aclk);
      check("r_stall_rvalid", 32'(rvalid), 32'd1);
      check("r_stall_rdata", rdata, data);
      check("r_stall_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic wait_core_idle();
    int n = 0;
    model_sync();
    while (m_busy && n < TMO) begin @(negedge aclk); model_sync(); n++; end
    if (m_busy) check("core_done_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge aclk);
  endtask

  typedef struct {
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [3:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] got;

  initial begin
    vecs[0] = '{4'h4, 32'h0000_0010, 4'hF, 4'h4, 32'h0000_0010};
    vecs[1] = '{4'h4, 32'hAABB_CCDD, 4'hC, 4'h4, 32'hAABB_0010};
    vecs[2] = '{4'h5, 32'h1122_3344, 4'h2, 4'h4, 32'hAABB_3310};
    vecs[3] = '{4'h8, 32'h1234_5678, 4'hF, 4'h8, 32'h0000_0000};
    vecs[4] = '{4'h0, 32'h0000_0002, 4'hF, 4'h0, 32'h0000_0002};
    vecs[5] = '{4'h0, 32'h0000_0000, 4'h0, 4'h1, 32'h0000_0002};
    vecs[6] = '{4'h0, 32'h0000_0000, 4'hF, 4'h0, 32'h0000_0000};
    vecs[7] = '{4'hC, 32'h0000_0007, 4'hF, 4'hE, 32'h0000_0000};
    vecs[8] = '{4'h4, 32'h0000_0010, 4'hF, 4'h4, 32'h0000_0010};

    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    #50;
    check_all_zero("reset");
    #150;
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Directed register vectors
    for (int i = 0; i < 9; i++) begin
      axi_write(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_strb, 0, 0, 0);
      axi_read(vecs[i].rd_addr, 0, got);
      check($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // W leads AW by three cycles, single-byte strobe
    axi_write(4'h4, 32'hFFFF_FFFF, 4'b0001, 3, 0, 0);
    axi_read(4'h4, 0, got);
    check("w_first_merge", got, 32'h0000_00FF);

    // Start / done / irq / W1C
    core_lat = 20; core_res_val = 32'h0000_0004;
    axi_write(4'h0, 32'h0000_0003, 4'hF, 0, 0, 0);
    axi_read(4'hC, 0, got);
    check("status_busy", got, 32'h0000_0001);
    wait_core_idle();
    axi_read(4'h8, 0, got);
    check("result", got, 32'h0000_0004);
    axi_read(4'hC, 0, got);
    check("status_done", got, 32'h0000_0002);
    check("irq_set", 32'(irq), 32'd1);
    axi_write(4'hC, 32'h0000_0002, 4'hF, 0, 0, 0);
    axi_read(4'hC, 0, got);
    check("status_w1c_done", got, 32'h0000_0000);
    check("irq_clr", 32'(irq), 32'd0);
    check("start_count1", 32'(starts), 32'(exp_starts));

    // START while busy raises ERR without a second pulse
    core_lat = 60; core_res_val = 32'h0000_1234;
    axi_write(4'h0, 32'h0000_0003, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'h0000_0003, 4'hF, 0, 2, 0);
    axi_read(4'hC, 0, got);
    check("status_err", got, 32'h0000_0005);
    check("start_count2", 32'(starts), 32'(exp_starts));
    axi_write(4'hC, 32'h0000_0004, 4'hF, 0, 0, 0);
    axi_read(4'hC, 0, got);
    check("status_w1c_err", got, 32'h0000_0001);
    wait_core_idle();
    axi_read(4'hC, 0, got);
    check("status_done2", got, 32'h0000_0002);
    axi_read(4'h8, 0, got);
    check("result2", got, 32'h0000_1234);
    check("core_start_width", 32'(width_viol), 32'd0);

    // Response back-pressure
    axi_write(4'h4, 32'h5A5A_5A5A, 4'hF, 0, 0, 10);
    axi_read(4'h4, 10, got);
    check("stall_read", got, 32'h5A5A_5A5A);

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (a[3:2] == 2'd0) d[0] = 1'b0;
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      end else begin
        axi_read(a, $urandom_range(0, 2), got);
        check($sformatf("rand_read%0d_a%0h", i, a), got, model_read(a));
      end
      check($sformatf("rand_irq%0d", i), 32'(irq), 32'(m_done & m_irq_en));
    end

    // Async reset mid-computation with a write response pending
    core_lat = 50;
    axi_write(4'h4, 32'hCAFE_0001, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'h0000_0003, 4'hF, 0, 0, 0);
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 4'h4; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < TMO && !bvalid; n++) @(negedge aclk);
    check("pre_reset_bvalid", 32'(bvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    m_operand = '0; m_result = '0; m_irq_en = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    seen_done = cm_done_cnt;
    repeat (2) @(negedge aclk);
    axi_read(4'hC, 0, got);
    check("post_reset_status", got, 32'h0000_0000);
    axi_read(4'h4, 0, got);
    check("post_reset_operand", got, 32'h0000_0000);
    repeat (60) @(negedge aclk);
    axi_read(4'h8, 0, got);
    check("post_reset_result", got, 32'h0000_0000);
    check("post_reset_irq", 32'(irq), 32'd0);
    check("final_start_count", 32'(starts), 32'(exp_starts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
